// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD subtractor: FSM states, BCD limits, fault codes.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_RADIX = 4'd10;

  // Code 2'b11 is not listed: it behaves exactly like FLT_NONE.
  localparam logic [1:0] FLT_NONE   = 2'b00;
  localparam logic [1:0] FLT_NOCORR = 2'b01;
  localparam logic [1:0] FLT_BINV   = 2'b10;

  function automatic logic digit_bad(input logic [3:0] v);
    return v > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Operand (in_*) and result (out_*) valid/ready handshakes of the serial BCD subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface bcd_serial_subtractor_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic [1:0]             fault;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   diff;
  logic                   neg;
  logic                   err;

  modport master (
    output in_valid, a, b, fault, out_ready,
    input  in_ready, out_valid, diff, neg, err
  );

  modport slave (
    input  in_valid, a, b, fault, out_ready,
    output in_ready, out_valid, diff, neg, err
  );
endinterface

// File: rtl/bcd_sub_digit.sv
// One BCD digit of A - B with borrow in/out; combinational, no handshake.
// Fault 01 drops the +10 correction, fault 10 inverts the borrow handed to the next digit.
module bcd_sub_digit
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin,
  input  logic [1:0] fault,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, bin};
    d   = raw[3:0];
    if (raw[4] && (fault != FLT_NOCORR)) begin
      d = raw[3:0] + BCD_RADIX;
    end
    bout = (fault == FLT_BINV) ? ~raw[4] : raw[4];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD A - B, LS digit first; result (ten's complement when A < B) valid NDIGITS edges after accept.
// One operation at a time: operands accepted only in IDLE, result held in DONE until out_ready.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bcd_serial_subtractor_if.slave        bus
);

  localparam int W    = 4 * NDIGITS;
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NDIGITS - 1);

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nxt;
  logic [W-1:0]    diff_q;
  logic [1:0]      fault_q;
  logic [IDXW-1:0] idx;
  logic            borrow;
  logic            err_acc;
  logic            neg_q;
  logic            err_q;
  logic            in_err;

  logic [3:0]      d;
  logic            bout;

  logic            in_ready_c;
  logic            out_valid_c;
  logic            accept;
  logic            last_digit;

  bcd_sub_digit u_digit (
    .a_i   (a_sr[3:0]),
    .b_i   (b_sr[3:0]),
    .bin   (borrow),
    .fault (fault_q),
    .d     (d),
    .bout  (bout)
  );

  assign accept     = bus.in_valid && in_ready_c;
  assign last_digit = (state == RUN) && (idx == LAST);
  assign acc_nxt    = {d, acc[W-1:4]};

  // Invalid digits are flagged up front so the result can be forced to zero on DONE entry.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      in_err = in_err | digit_bad(bus.a[4*i +: 4]) | digit_bad(bus.b[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state == IDLE);
    out_valid_c = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      diff_q  <= '0;
      fault_q <= FLT_NONE;
      idx     <= '0;
      borrow  <= 1'b0;
      err_acc <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      a_sr    <= bus.a;
      b_sr    <= bus.b;
      fault_q <= bus.fault;
      idx     <= '0;
      borrow  <= 1'b0;
      err_acc <= in_err;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 4;
      b_sr   <= b_sr >> 4;
      acc    <= acc_nxt;
      borrow <= bout;
      idx    <= idx + 1'b1;
      // Visible outputs move only here, so they stay stable through RUN and DONE.
      if (last_digit) begin
        diff_q <= err_acc ? '0 : acc_nxt;
        neg_q  <= err_acc ? 1'b0 : bout;
        err_q  <= err_acc;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized and directed bench for bcd_serial_subtractor against a decimal/per-digit reference model.
module tb_bcd_serial_subtractor;

  localparam int NDIG = 4;
  localparam int LAT  = NDIG + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [4*NDIG-1:0] last_diff = '0;

  bcd_serial_subtractor_if #(.NDIGITS(NDIG)) bus();

  bcd_serial_subtractor #(.NDIGITS(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fault-free results come from whole-number decimal subtraction; fault modes follow the digit rules.
  function automatic void model(input logic [4*NDIG-1:0] a, input logic [4*NDIG-1:0] b,
                                input logic [1:0] f, output logic [4*NDIG-1:0] d,
                                output logic n, output logic e);
    int av, bv, r, t, da, db, bin, bo;
    av = 0; bv = 0; e = 1'b0; n = 1'b0; d = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) e = 1'b1;
      av = av * 10 + da;
      bv = bv * 10 + db;
    end
    if (e) return;
    if (f == 2'b01 || f == 2'b10) begin
      bin = 0;
      for (int i = 0; i < NDIG; i++) begin
        t  = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - bin;
        bo = (t < 0) ? 1 : 0;
        if (bo == 1) t = t + ((f == 2'b01) ? 16 : 10);
        d[4*i +: 4] = t[3:0];
        bin = (f == 2'b10) ? 1 - bo : bo;
      end
      n = (bin != 0);
    end else begin
      r = av - bv;
      n = (r < 0);
      if (n) r = r + 10 ** NDIG;
      for (int i = 0; i < NDIG; i++) begin
        d[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
  endfunction

  task automatic run_op(input logic [4*NDIG-1:0] a, input logic [4*NDIG-1:0] b,
                        input logic [1:0] f, input int hold);
    logic [4*NDIG-1:0] ed;
    logic en, ee;
    int lat, w;
    model(a, b, f, ed, en, ee);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.fault = f; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.fault = 2'($urandom);
    if (hold == 0) bus.out_ready = 1'b1;
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    check("diff_held_run", 32'(bus.diff), 32'(last_diff));
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("diff", 32'(bus.diff), 32'(ed));
    check("neg", 32'(bus.neg), 32'(en));
    check("err", 32'(bus.err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_diff", 32'(bus.diff), 32'(ed));
      check("hold_neg", 32'(bus.neg), 32'(en));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_idle", 32'(bus.in_ready), 32'd1);
    check("release_diff", 32'(bus.diff), 32'(ed));
    last_diff = ed;
  endtask

  function automatic logic [4*NDIG-1:0] rand_bcd();
    logic [4*NDIG-1:0] v;
    for (int i = 0; i < NDIG; i++) begin
      if ($urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.fault = 2'b00; bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(16'h4321, 16'h1234, 2'b00, 0);
    check("dir_4321_1234", 32'(bus.diff), 32'h3087);
    run_op(16'h0000, 16'h0001, 2'b00, 1);
    check("dir_0000_0001", 32'(bus.diff), 32'h9999);
    run_op(16'h1000, 16'h0001, 2'b00, 0);
    check("dir_ripple", 32'(bus.diff), 32'h0999);
    run_op(16'h00A0, 16'h0001, 2'b00, 0);
    check("dir_bad_digit", 32'(bus.err), 32'd1);
    run_op(16'h0003, 16'h0007, 2'b01, 0);
    run_op(16'h0003, 16'h0007, 2'b10, 0);
    check("dir_binv_d0", 32'(bus.diff[3:0]), 32'd6);
    run_op(16'h0003, 16'h0007, 2'b11, 0);
    check("dir_f11", 32'(bus.diff), 32'h9996);
    run_op(16'h9999, 16'h9999, 2'b00, 5);

    // Reset while digit 2 is being processed.
    run_op(16'h4321, 16'h1234, 2'b00, 0);
    bus.a = 16'h5555; bus.b = 16'h1111; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrun_rst_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_rst_diff", 32'(bus.diff), 32'd0);
    check("midrun_rst_neg", 32'(bus.neg), 32'd0);
    rst_n = 1'b1;
    last_diff = '0;
    run_op(16'h4321, 16'h1234, 2'b00, 1);

    for (int k = 0; k < 60; k++) begin
      run_op(rand_bcd(), rand_bcd(), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
